// File: rtl/psr_bank.sv
// ---------------------------------------------------------------------------
// psr_bank -- program-status register bank at the execute/writeback boundary.
//
// Holds the current condition flags (NZCV at the default width). The flags
// are loaded from the ALU (s_en) or under a bit mask from MSR (msr_en). A
// DEPTH-entry saved-status stack is pushed on exception entry and popped on
// exception return, so nested exceptions restore their flags. One operation
// per cycle, fixed priority: rst > exc_entry > exc_ret > msr_en > s_en > hold.
// Every output is a register.
//
// Optional feature macro: PSR_QFLAG_EN
//   Adds the sticky saturation flag Q (q_set, msr_q_clr, q_out). Q is saved
//   and restored with the flags, so stack entries become FLAG_W+1 bits wide.
//
// Parameters
//   FLAG_W   number of flag bits (MSB = N, then Z, C, V)
//   DEPTH    saved-status stack entries (>= 1)
//   DEPTH_W  width of the depth count, 2**DEPTH_W > DEPTH
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   flags_in     ALU result flags, loaded when s_en
//   s_en         load flags_in into the current flags
//   msr_en       masked write of the current flags
//   msr_data     MSR value
//   msr_mask     1 = bit written by MSR, 0 = bit held
//   exc_entry    push current flags onto the stack
//   exc_ret      pop the top entry into the current flags
//   flags_out    current flags
//   spsr_out     top-of-stack flags, 0 when the stack is empty
//   depth        number of valid stack entries
//   stack_full   depth == DEPTH
//   stack_empty  depth == 0
//   stack_err    one-cycle pulse on push-when-full or pop-when-empty
//   q_set        (PSR_QFLAG_EN) set sticky Q
//   msr_q_clr    (PSR_QFLAG_EN) clear Q together with msr_en
//   q_out        (PSR_QFLAG_EN) sticky saturation flag
// ---------------------------------------------------------------------------
module psr_bank #(
  parameter int FLAG_W  = 4,
  parameter int DEPTH   = 4,
  parameter int DEPTH_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLAG_W-1:0]  flags_in,
  input  logic               s_en,
  input  logic               msr_en,
  input  logic [FLAG_W-1:0]  msr_data,
  input  logic [FLAG_W-1:0]  msr_mask,
  input  logic               exc_entry,
  input  logic               exc_ret,
  output logic [FLAG_W-1:0]  flags_out,
  output logic [FLAG_W-1:0]  spsr_out,
  output logic [DEPTH_W-1:0] depth,
  output logic               stack_full,
  output logic               stack_empty,
  output logic               stack_err
`ifdef PSR_QFLAG_EN
  ,
  input  logic               q_set,
  input  logic               msr_q_clr,
  output logic               q_out
`endif
);

`ifdef PSR_QFLAG_EN
  localparam int ENT_W = FLAG_W + 1;  // {Q, flags}
`else
  localparam int ENT_W = FLAG_W;
`endif
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);
  localparam logic [DEPTH_W-1:0] D_ZERO    = '0;
  localparam logic [DEPTH_W-1:0] D_ONE     = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] D_TWO     = DEPTH_W'(2);

  logic [FLAG_W-1:0]  flags_q, flags_d;
  logic [FLAG_W-1:0]  spsr_q,  spsr_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               full_q,  full_d;
  logic               empty_q, empty_d;
  logic               err_q,   err_d;

  logic [ENT_W-1:0]   stack_q [DEPTH];
  logic               push_en;
  logic [ENT_W-1:0]   cur_ent;
  logic [ENT_W-1:0]   top_ent;
  logic [ENT_W-1:0]   below_ent;
  logic [IDX_W-1:0]   wr_idx, top_idx, below_idx;

`ifdef PSR_QFLAG_EN
  logic q_q, q_d;
  assign cur_ent = {q_q, flags_q};
`else
  assign cur_ent = flags_q;
`endif

  // Push writes at depth; a pop reads depth-1 into the flags and exposes
  // depth-2 as the new top of stack. Out-of-range indices only occur in
  // cycles where the value is not used.
  assign wr_idx    = IDX_W'(depth_q);
  assign top_idx   = IDX_W'(depth_q - D_ONE);
  assign below_idx = IDX_W'(depth_q - D_TWO);
  assign top_ent   = stack_q[top_idx];
  assign below_ent = stack_q[below_idx];

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    flags_d = flags_q;
    spsr_d  = spsr_q;
    depth_d = depth_q;
    err_d   = 1'b0;
    push_en = 1'b0;
`ifdef PSR_QFLAG_EN
    q_d     = q_q;
`endif

    if (exc_entry) begin
      // Entry wins; exc_ret/msr/s (and q_set) in the same cycle are dropped,
      // even when the push itself faults.
      if (depth_q != DEPTH_MAX) begin
        push_en = 1'b1;
        depth_d = depth_q + D_ONE;
        spsr_d  = flags_q;
      end else begin
        err_d = 1'b1;
      end
    end else if (exc_ret) begin
      if (depth_q != D_ZERO) begin
        flags_d = top_ent[FLAG_W-1:0];
`ifdef PSR_QFLAG_EN
        q_d     = top_ent[FLAG_W];
`endif
        depth_d = depth_q - D_ONE;
        spsr_d  = (depth_q > D_ONE) ? below_ent[FLAG_W-1:0] : '0;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      if (msr_en) begin
        flags_d = (msr_data & msr_mask) | (flags_q & ~msr_mask);
      end else if (s_en) begin
        flags_d = flags_in;
      end
`ifdef PSR_QFLAG_EN
      // Set beats clear when both arrive together.
      if (q_set) begin
        q_d = 1'b1;
      end else if (msr_en && msr_q_clr) begin
        q_d = 1'b0;
      end
`endif
    end

    full_d  = (depth_d == DEPTH_MAX);
    empty_d = (depth_d == D_ZERO);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      spsr_q  <= '0;
      depth_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
`ifdef PSR_QFLAG_EN
      q_q     <= 1'b0;
`endif
    end else begin
      flags_q <= flags_d;
      spsr_q  <= spsr_d;
      depth_q <= depth_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      err_q   <= err_d;
`ifdef PSR_QFLAG_EN
      q_q     <= q_d;
`endif
    end
  end

  // NOTE: the stack storage is not reset; depth_q alone decides which
  // entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push_en && !rst) begin
      stack_q[wr_idx] <= cur_ent;
    end
  end

  assign flags_out   = flags_q;
  assign spsr_out    = spsr_q;
  assign depth       = depth_q;
  assign stack_full  = full_q;
  assign stack_empty = empty_q;
  assign stack_err   = err_q;
`ifdef PSR_QFLAG_EN
  assign q_out       = q_q;
`endif

endmodule

// File: tb/tb_psr_bank.sv
// ---------------------------------------------------------------------------
// tb_psr_bank -- self-checking bench for psr_bank (default build).
// Directed scenarios compare against fixed expected values; a randomized
// phase compares every output against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_psr_bank;
  localparam int FLAG_W  = 4;
  localparam int DEPTH   = 4;
  localparam int DEPTH_W = 3;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [FLAG_W-1:0]  flags_in = '0;
  logic               s_en = 1'b0;
  logic               msr_en = 1'b0;
  logic [FLAG_W-1:0]  msr_data = '0;
  logic [FLAG_W-1:0]  msr_mask = '0;
  logic               exc_entry = 1'b0;
  logic               exc_ret = 1'b0;
  logic [FLAG_W-1:0]  flags_out;
  logic [FLAG_W-1:0]  spsr_out;
  logic [DEPTH_W-1:0] depth;
  logic               stack_full;
  logic               stack_empty;
  logic               stack_err;
`ifdef PSR_QFLAG_EN
  logic               q_set = 1'b0;
  logic               msr_q_clr = 1'b0;
  logic               q_out;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: current flags, a queue as the saved-status stack and
  // the expected error pulse.
  logic [FLAG_W-1:0] m_flags = '0;
  logic [FLAG_W-1:0] m_stack [$];
  logic              m_err = 1'b0;

  psr_bank #(.FLAG_W(FLAG_W), .DEPTH(DEPTH), .DEPTH_W(DEPTH_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flags_in    (flags_in),
    .s_en        (s_en),
    .msr_en      (msr_en),
    .msr_data    (msr_data),
    .msr_mask    (msr_mask),
    .exc_entry   (exc_entry),
    .exc_ret     (exc_ret),
    .flags_out   (flags_out),
    .spsr_out    (spsr_out),
    .depth       (depth),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
`ifdef PSR_QFLAG_EN
    ,
    .q_set       (q_set),
    .msr_q_clr   (msr_q_clr),
    .q_out       (q_out)
`endif
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, clock once, sample 1 time unit after the
  // edge and advance the reference model.
  task automatic cycle(input logic rs, input logic ent, input logic ret,
                       input logic msr, input logic s,
                       input logic [FLAG_W-1:0] fin,
                       input logic [FLAG_W-1:0] md,
                       input logic [FLAG_W-1:0] mm);
    rst = rs; exc_entry = ent; exc_ret = ret; msr_en = msr; s_en = s;
    flags_in = fin; msr_data = md; msr_mask = mm;
    @(posedge clk);
    #1;
    m_err = 1'b0;
    if (rs) begin
      m_flags = '0;
      m_stack.delete();
    end else if (ent) begin
      if (m_stack.size() == DEPTH) m_err = 1'b1;
      else m_stack.push_back(m_flags);
    end else if (ret) begin
      if (m_stack.size() == 0) m_err = 1'b1;
      else m_flags = m_stack.pop_back();
    end else if (msr) begin
      m_flags = (md & mm) | (m_flags & ~mm);
    end else if (s) begin
      m_flags = fin;
    end
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, '0, '0, '0);
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, 0, '0, '0, '0);
    checks++; if (flags_out !== 4'b0000) begin errors++; $display("FAIL reset_flags got=%b exp=0000", flags_out); end
    checks++; if (depth !== 3'd0) begin errors++; $display("FAIL reset_depth got=%0d exp=0", depth); end
    checks++; if (spsr_out !== 4'b0000) begin errors++; $display("FAIL reset_spsr got=%b exp=0000", spsr_out); end
    checks++; if (stack_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", stack_empty); end
    checks++; if (stack_full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", stack_full); end
    checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", stack_err); end
    idle();
  endtask

  task automatic test_s_msr();
    cycle(0, 0, 0, 0, 1, 4'b1010, '0, '0);
    checks++; if (flags_out !== 4'b1010) begin errors++; $display("FAIL s_update got=%b exp=1010", flags_out); end
    cycle(0, 0, 0, 1, 0, '0, 4'b0101, 4'b0011);
    checks++; if (flags_out !== 4'b1001) begin errors++; $display("FAIL msr_masked got=%b exp=1001", flags_out); end
    // all-zero mask: no change, and the same-cycle s_en is still suppressed
    cycle(0, 0, 0, 1, 1, 4'b0110, 4'b1111, 4'b0000);
    checks++; if (flags_out !== 4'b1001) begin errors++; $display("FAIL msr_zero_mask got=%b exp=1001", flags_out); end
  endtask

  task automatic test_nesting();
    cycle(0, 0, 0, 0, 1, 4'b1000, '0, '0);
    cycle(0, 1, 0, 0, 0, '0, '0, '0);
    cycle(0, 0, 0, 0, 1, 4'b0100, '0, '0);
    cycle(0, 1, 0, 0, 0, '0, '0, '0);
    checks++; if (depth !== 3'd2) begin errors++; $display("FAIL nest_depth got=%0d exp=2", depth); end
    checks++; if (spsr_out !== 4'b0100) begin errors++; $display("FAIL nest_spsr got=%b exp=0100", spsr_out); end
    cycle(0, 0, 1, 0, 0, '0, '0, '0);
    checks++; if (flags_out !== 4'b0100) begin errors++; $display("FAIL nest_pop1 got=%b exp=0100", flags_out); end
    checks++; if (spsr_out !== 4'b1000) begin errors++; $display("FAIL nest_pop1_spsr got=%b exp=1000", spsr_out); end
    cycle(0, 0, 1, 0, 0, '0, '0, '0);
    checks++; if (flags_out !== 4'b1000) begin errors++; $display("FAIL nest_pop2 got=%b exp=1000", flags_out); end
    checks++; if (depth !== 3'd0) begin errors++; $display("FAIL nest_pop2_depth got=%0d exp=0", depth); end
    checks++; if (spsr_out !== 4'b0000) begin errors++; $display("FAIL nest_pop2_spsr got=%b exp=0000", spsr_out); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 0, 0, 0, 1, FLAG_W'(i + 1), '0, '0);
      cycle(0, 1, 0, 0, 0, '0, '0, '0);
      checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL ovf_err_early push=%0d got=%b exp=0", i, stack_err); end
    end
    cycle(0, 1, 0, 0, 1, 4'b1111, '0, '0);
    checks++; if (stack_err !== 1'b1) begin errors++; $display("FAIL ovf_err got=%b exp=1", stack_err); end
    checks++; if (depth !== 3'd4) begin errors++; $display("FAIL ovf_depth got=%0d exp=4", depth); end
    checks++; if (stack_full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b exp=1", stack_full); end
    checks++; if (spsr_out !== 4'b0100) begin errors++; $display("FAIL ovf_spsr got=%b exp=0100", spsr_out); end
    checks++; if (flags_out !== 4'b0100) begin errors++; $display("FAIL ovf_flags got=%b exp=0100", flags_out); end
    idle();
    checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL ovf_err_pulse got=%b exp=0", stack_err); end
    for (int i = DEPTH; i >= 1; i--) begin
      cycle(0, 0, 1, 0, 0, '0, '0, '0);
      checks++; if (flags_out !== FLAG_W'(i)) begin errors++; $display("FAIL ovf_unwind got=%b exp=%b", flags_out, FLAG_W'(i)); end
    end
    checks++; if (stack_empty !== 1'b1) begin errors++; $display("FAIL ovf_empty got=%b exp=1", stack_empty); end
  endtask

  task automatic test_underflow();
    cycle(0, 0, 1, 1, 1, 4'b1111, 4'b1111, 4'b1111);
    checks++; if (stack_err !== 1'b1) begin errors++; $display("FAIL unf_err got=%b exp=1", stack_err); end
    checks++; if (flags_out !== 4'b0001) begin errors++; $display("FAIL unf_flags got=%b exp=0001", flags_out); end
    checks++; if (depth !== 3'd0) begin errors++; $display("FAIL unf_depth got=%0d exp=0", depth); end
    idle();
    checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL unf_err_pulse got=%b exp=0", stack_err); end
  endtask

  task automatic test_simultaneous();
    cycle(0, 1, 1, 0, 1, 4'b1111, '0, '0);
    checks++; if (flags_out !== 4'b0001) begin errors++; $display("FAIL sim_push_flags got=%b exp=0001", flags_out); end
    checks++; if (depth !== 3'd1) begin errors++; $display("FAIL sim_push_depth got=%0d exp=1", depth); end
    checks++; if (spsr_out !== 4'b0001) begin errors++; $display("FAIL sim_push_spsr got=%b exp=0001", spsr_out); end
    cycle(0, 0, 0, 1, 1, 4'b1111, 4'b0110, 4'b1111);
    checks++; if (flags_out !== 4'b0110) begin errors++; $display("FAIL sim_msr_s got=%b exp=0110", flags_out); end
    // pop beats same-cycle msr and s
    cycle(0, 0, 1, 1, 1, 4'b1111, 4'b1010, 4'b1111);
    checks++; if (flags_out !== 4'b0001) begin errors++; $display("FAIL sim_pop got=%b exp=0001", flags_out); end
  endtask

  task automatic test_random();
    logic rs, ent, ret, msr, s;
    logic [FLAG_W-1:0] fin, md, mm, exp_spsr;
    for (int n = 0; n < 400; n++) begin
      rs  = ($urandom_range(0, 39) == 0);
      ent = ($urandom_range(0, 3) == 0);
      ret = ($urandom_range(0, 3) == 0);
      msr = ($urandom_range(0, 2) == 0);
      s   = ($urandom_range(0, 1) == 0);
      fin = FLAG_W'($urandom); md = FLAG_W'($urandom); mm = FLAG_W'($urandom);
      cycle(rs, ent, ret, msr, s, fin, md, mm);
      exp_spsr = (m_stack.size() > 0) ? m_stack[$] : '0;
      checks++; if (flags_out !== m_flags) begin errors++; $display("FAIL rnd_flags n=%0d got=%b exp=%b", n, flags_out, m_flags); end
      checks++; if (depth !== DEPTH_W'(m_stack.size())) begin errors++; $display("FAIL rnd_depth n=%0d got=%0d exp=%0d", n, depth, m_stack.size()); end
      checks++; if (spsr_out !== exp_spsr) begin errors++; $display("FAIL rnd_spsr n=%0d got=%b exp=%b", n, spsr_out, exp_spsr); end
      checks++; if (stack_full !== (m_stack.size() == DEPTH)) begin errors++; $display("FAIL rnd_full n=%0d got=%b", n, stack_full); end
      checks++; if (stack_empty !== (m_stack.size() == 0)) begin errors++; $display("FAIL rnd_empty n=%0d got=%b", n, stack_empty); end
      checks++; if (stack_err !== m_err) begin errors++; $display("FAIL rnd_err n=%0d got=%b exp=%b", n, stack_err, m_err); end
    end
  endtask

  task automatic test_reset_mid_nest();
    cycle(0, 1, 0, 0, 0, '0, '0, '0);
    cycle(0, 1, 0, 0, 0, '0, '0, '0);
    cycle(1, 1, 0, 0, 1, 4'b1111, '0, '0);
    checks++; if (depth !== 3'd0) begin errors++; $display("FAIL rst_nest_depth got=%0d exp=0", depth); end
    checks++; if (flags_out !== 4'b0000) begin errors++; $display("FAIL rst_nest_flags got=%b exp=0000", flags_out); end
    checks++; if (spsr_out !== 4'b0000) begin errors++; $display("FAIL rst_nest_spsr got=%b exp=0000", spsr_out); end
  endtask

  initial begin
    test_reset();
    test_s_msr();
    test_nesting();
    test_overflow();
    test_underflow();
    test_simultaneous();
    test_random();
    test_reset_mid_nest();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psr_bank.md
# psr_bank

Parametrised program-status register bank for the pipeline's execute/writeback boundary. It holds the current condition flags (NZCV by default). Flags update from the ALU when `s_en` is high, or under a bit mask from MSR. A DEPTH-entry saved-status stack is pushed on exception entry and popped on exception return, so nested exceptions restore flags correctly. All outputs are registered, and the branch/condition unit consumes `flags_out` directly.

## Interface
- `FLAG_W`, default 4: number of flag bits; bit FLAG_W-1 = N, then Z, C, V down to bit 0 at the default width.
- `DEPTH`, default 4: saved-status stack entries, ≥1.
- `DEPTH_W`, default 3: width of the depth count; must satisfy 2^DEPTH_W > DEPTH.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `flags_in` input FLAG_W: ALU result flags.
- `s_en` input 1: load `flags_in` into the current flags.
- `msr_en` input 1: masked write of the current flags.
- `msr_data` input FLAG_W: MSR value.
- `msr_mask` input FLAG_W: 1 = bit written by MSR, 0 = bit held.
- `exc_entry` input 1: push current flags onto the stack.
- `exc_ret` input 1: pop the top entry into the current flags.
- `flags_out` output FLAG_W: current flags.
- `spsr_out` output FLAG_W: top-of-stack entry; 0 when the stack is empty.
- `depth` output DEPTH_W: number of valid stack entries.
- `stack_full` output 1: `depth == DEPTH`.
- `stack_empty` output 1: `depth == 0`.
- `stack_err` output 1: one-cycle pulse on push-when-full or pop-when-empty.
- `q_set` input 1: only with PSR_QFLAG_EN; sets the sticky Q flag.
- `msr_q_clr` input 1: only with PSR_QFLAG_EN; clears Q when `msr_en` is also high.
- `q_out` output 1: only with PSR_QFLAG_EN; sticky saturation flag.

## Operation
- One operation per cycle, chosen by fixed priority: `rst` > `exc_entry` > `exc_ret` > `msr_en` > `s_en` > hold.
- **Reset:**
  - `flags_out` = 0, `depth` = 0, `spsr_out` = 0.
  - `stack_empty` = 1, `stack_full` = 0, `stack_err` = 0, `q_out` = 0.
  - Stack storage contents are don't-care.
- **exc_entry with depth < DEPTH:**
  - stack[depth] ← `flags_out` (pre-edge value); `depth` +1.
  - Current flags are unchanged; any same-cycle `exc_ret`, `msr_en` or `s_en` is discarded.
- **exc_entry with depth == DEPTH:**
  - Nothing changes; `stack_err` pulses.
  - Same-cycle lower-priority requests are still discarded.
- **exc_ret with depth > 0:**
  - `flags_out` ← stack[depth-1]; `depth` −1.
  - Same-cycle MSR and S updates are discarded.
- **exc_ret with depth == 0:**
  - Nothing changes; `stack_err` pulses; MSR and S updates are discarded.
- **MSR:** `flags_out` ← (`msr_data` & `msr_mask`) | (`flags_out` & ~`msr_mask`). With an all-zero mask this is a no-op, but `s_en` is still suppressed.
- **S update:** `flags_out` ← `flags_in`.
- **Hold:** every register keeps its value.
- **Derived outputs:** `spsr_out`, `stack_full` and `stack_empty` are registered values consistent with the post-edge `depth`.

## Timing
- All state changes occur on the rising edge of `clk`; reset is sampled on that edge only.
- Latency is one cycle: inputs sampled at edge k are visible on the outputs after edge k.
- `stack_err` is high for exactly the cycle following the faulting edge.
- Back-to-back push/pop on consecutive cycles is fully supported, with no bubble.
- Reset asserted mid-nest discards all saved entries.

## Configuration
- `PSR_QFLAG_EN` defined:
  - Adds `q_set`, `msr_q_clr` and `q_out`; stack entries grow to FLAG_W+1 bits and carry Q.
  - Q is set by `q_set` in any cycle not overridden by reset, push or pop.
  - Q is cleared only by `msr_en` & `msr_q_clr`; if `q_set` is also high that cycle, Q ends at 1.
  - Push saves Q; pop restores Q; `s_en` never clears Q.
- `PSR_QFLAG_EN` undefined: the three ports are absent and stack entries are FLAG_W bits.

## Test plan
- **Reset, S update, MSR:** reset, then `s_en`=1 with `flags_in`=4'b1010 → `flags_out`=4'b1010 after one edge. Then `msr_en`, `msr_data`=4'b0101, `msr_mask`=4'b0011 → `flags_out`=4'b1001.
- **Nesting:** with flags 4'b1000, push; set flags to 4'b0100 via `s_en`; push → `depth`=2, `spsr_out`=4'b0100. Pop → `flags_out`=4'b0100; pop → `flags_out`=4'b1000, `depth`=0, `spsr_out`=0.
- **Overflow:** with DEPTH=4, push 5 times → `stack_full`=1, `depth`=4, one `stack_err` pulse on the 5th push, stack top unchanged.
- **Underflow:** pop at `depth`=0 → one `stack_err` pulse, `flags_out` unchanged.
- **Simultaneous events:**
  - `exc_entry`+`exc_ret`+`s_en` with `flags_in`=4'b1111 → push only, `flags_out` unchanged.
  - `msr_en`+`s_en` → MSR result only.
- **Q flag (PSR_QFLAG_EN):**
  - `q_set` → `q_out`=1; push; `msr_en`+`msr_q_clr` → `q_out`=0; pop → `q_out`=1.
  - Assert `rst` mid-nest → `depth`=0, `q_out`=0.
